// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 8:1 mux: steps the selects 0..7, samples y_in after a settle wait,
// and presents the assembled byte with a one-clock valid strobe. Define MUX_SCAN_CONT_EN for back-to-back scans.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] shadow, shadow_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, busy_nxt;

  // Selects come straight off the idx flops, so they are glitch-free and track idx exactly.
  assign {sel2, sel1, sel0} = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      shadow   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      data_out <= data_nxt;
      valid    <= valid_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    data_nxt   = data_out;
    valid_nxt  = 1'b0;
    busy_nxt   = busy;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SETTLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else begin
          shadow_nxt[idx] = y_in;
          if (idx != 3'd7) begin
            idx_nxt   = idx + 3'd1;
            state_nxt = SETTLE;
          end else begin
            // Channel 7 bypasses the shadow so the word is ready on the completing edge.
            data_nxt  = {y_in, shadow[6:0]};
            valid_nxt = 1'b1;
            idx_nxt   = '0;
            cnt_nxt   = '0;
`ifdef MUX_SCAN_CONT_EN
            state_nxt = SETTLE;
`else
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
